// File: rtl/uar_rx_fifo.sv
// uar_rx_fifo: receive-side character buffer behind the UART receiver.
// Captures one character per rising edge of RxDone into a circular FIFO.
// Presents the oldest character on a first-word-fall-through valid/ready
// port. Reports occupancy and a sticky overflow flag.
//
// Handshake: m_tvalid is high whenever the FIFO holds at least one byte, and
// m_tdata then shows the oldest byte. A byte is transferred (popped) on every
// rising Clk edge where m_tvalid & m_tready. While m_tvalid & ~m_tready,
// m_tdata and m_tvalid hold. m_tvalid never depends combinationally on
// m_tready.
module uar_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RxDone,
  input  logic [DATA_W-1:0] RxData,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  input  logic              OvfClr
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              done_q, done_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic push;
  logic pop;
  logic accept;
  logic drop;

  // Status comes straight from the occupancy register; the pointers are never compared.
  assign Count    = count_q;
  assign Full     = (count_q == FULL_CNT);
  assign Empty    = (count_q == '0);
  assign Overflow = ovf_q;
  assign m_tvalid = ~Empty;
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;

  // Edge detect on the strobe, handshake decode, and accept/drop decision.
  always_comb begin
    push   = RxDone & ~done_q;
    pop    = m_tvalid & m_tready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    accept = push & (~Full | pop);
    drop   = push & Full & ~pop;
  end

  // Next-state for the edge detector, pointers, occupancy and overflow flag.
  always_comb begin
    done_d   = RxDone;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (accept && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !accept) begin
      count_d = count_q - CNT_ONE;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OvfClr) begin
      ovf_d = 1'b0;
    end
  end

  // Control registers; reset empties the FIFO in a single cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are not reset, and a write is suppressed during reset.
  always_ff @(posedge Clk) begin
    if (!Rst && accept) begin
      mem_q[wr_ptr_q] <= RxData;
    end
  end

endmodule

// File: tb/tb_uar_rx_fifo.sv
// tb_uar_rx_fifo: directed, scoreboard-checked bench for uar_rx_fifo.
module tb_uar_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  // ---------------- clock / reset ----------------
  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              RxDone = 1'b0;
  logic [DATA_W-1:0] RxData = '0;
  logic              m_tready = 1'b0;
  logic              OvfClr = 1'b0;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic [ADDR_W:0]   Count;
  logic              Full;
  logic              Empty;
  logic              Overflow;

  always #5 Clk = ~Clk;

  uar_rx_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RxDone   (RxDone),
    .RxData   (RxData),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .Count    (Count),
    .Full     (Full),
    .Empty    (Empty),
    .Overflow (Overflow),
    .OvfClr   (OvfClr)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              ovf_m = 1'b0;
  logic              prev_done_m = 1'b0;
  int                checks = 0;
  int                failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output with the scoreboard after a clock edge.
  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({tag, ":count"},  32'(Count),    32'(exp_q.size()));
    chk({tag, ":valid"},  32'(m_tvalid), 32'(exp_q.size() != 0));
    chk({tag, ":empty"},  32'(Empty),    32'(exp_q.size() == 0));
    chk({tag, ":full"},   32'(Full),     32'(exp_q.size() == DEPTH));
    chk({tag, ":ovf"},    32'(Overflow), 32'(ovf_m));
    chk({tag, ":tdata"},  32'(m_tdata),  32'(head));
  endtask

  // ---------------- driver ----------------
  // One clock cycle with the given inputs; the scoreboard predicts the effect.
  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic cycle(input string tag, input logic rd, input logic [DATA_W-1:0] rdat,
                       input logic trdy, input logic clr);
    logic full_m, pop_m, push_m;
    RxDone   = rd;
    RxData   = rdat;
    m_tready = trdy;
    OvfClr   = clr;
    #1;
    full_m = (exp_q.size() == DEPTH);
    pop_m  = trdy && (exp_q.size() != 0);
    push_m = rd && !prev_done_m;
    if (pop_m) begin
      chk({tag, ":pop_data"}, 32'(m_tdata), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (push_m) begin
      if (!full_m || pop_m) exp_q.push_back(rdat);
      else ovf_m = 1'b1;
    end else if (clr) begin
      ovf_m = 1'b0;
    end
    if (push_m && full_m && !pop_m) ovf_m = 1'b1;
    prev_done_m = rd;
    @(posedge Clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic push_byte(input string tag, input logic [DATA_W-1:0] b);
    cycle(tag, 1'b1, b, 1'b0, 1'b0);
    cycle(tag, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Reset cycle with a push, a pop and a clear all requested; reset must dominate.
  task automatic reset_cycle(input string tag);
    Rst      = 1'b1;
    RxDone   = 1'b1;
    RxData   = 8'hC3;
    m_tready = 1'b1;
    OvfClr   = 1'b1;
    @(posedge Clk);
    #1;
    Rst      = 1'b0;
    RxDone   = 1'b0;
    m_tready = 1'b0;
    OvfClr   = 1'b0;
    exp_q.delete();
    ovf_m       = 1'b0;
    prev_done_m = 1'b0;
    check_outputs(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] held_data;
    logic              held_valid;

    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check_outputs("reset");

    // Basic push then pop.
    cycle("basic_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("basic_push:tdata_a5", 32'(m_tdata), 32'h0000_00A5);
    chk("basic_push:count1", 32'(Count), 32'd1);
    cycle("basic_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("basic_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("basic_pop:empty", 32'(Empty), 32'd1);
    chk("basic_pop:tdata0", 32'(m_tdata), 32'd0);

    // Fill to full, then wrap the pointers.
    for (int i = 0; i < DEPTH; i++) push_byte("fill", 8'(i));
    chk("fill:full", 32'(Full), 32'd1);
    chk("fill:count16", 32'(Count), 32'd16);
    for (int i = 0; i < 4; i++) cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push_byte("wrap_push", 8'(8'h10 + i));
    drain("wrap_drain");

    // Overflow: drop, drop with clear (set wins), clear alone.
    for (int i = 0; i < DEPTH; i++) push_byte("ovf_fill", 8'($urandom_range(0, 255)));
    cycle("ovf_drop", 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_drop:flag", 32'(Overflow), 32'd1);
    chk("ovf_drop:count16", 32'(Count), 32'd16);
    cycle("ovf_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("ovf_set_wins", 1'b1, 8'hEF, 1'b0, 1'b1);
    chk("ovf_set_wins:flag", 32'(Overflow), 32'd1);
    cycle("ovf_idle2", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clear:flag", 32'(Overflow), 32'd0);

    // Full FIFO, push and pop together: count stays, new byte goes to the tail.
    cycle("full_pushpop", 1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_pushpop:count16", 32'(Count), 32'd16);
    cycle("full_pushpop_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    drain("full_drain");

    // Single entry, push and pop together.
    push_byte("one_push", 8'h77);
    cycle("one_pushpop", 1'b1, 8'h78, 1'b1, 1'b0);
    chk("one_pushpop:count1", 32'(Count), 32'd1);
    chk("one_pushpop:valid", 32'(m_tvalid), 32'd1);
    cycle("one_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    drain("one_drain");

    // Stretched strobe gives a single write; backpressure holds the output.
    for (int i = 0; i < 5; i++) cycle("stretch", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("stretch_low", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("stretch:count1", 32'(Count), 32'd1);
    held_data  = m_tdata;
    held_valid = m_tvalid;
    for (int i = 0; i < 10; i++) begin
      cycle("hold", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("hold:tdata_stable", 32'(m_tdata), 32'h0000_003C);
      chk("hold:valid_stable", 32'(m_tvalid), 32'(held_valid));
    end
    chk("hold:captured", 32'(held_data), 32'h0000_003C);
    drain("stretch_drain");

    // Reset mid-operation with Count=7 and Overflow set.
    for (int i = 0; i < DEPTH; i++) push_byte("rst_fill", 8'($urandom_range(0, 255)));
    push_byte("rst_drop", 8'hEE);
    for (int i = 0; i < 9; i++) cycle("rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_pre:count7", 32'(Count), 32'd7);
    chk("rst_pre:ovf", 32'(Overflow), 32'd1);
    reset_cycle("rst_mid");
    chk("rst_mid:count0", 32'(Count), 32'd0);
    chk("rst_mid:ovf0", 32'(Overflow), 32'd0);

    // RxDone high on the first cycle after reset release counts as an edge.
    reset_cycle("rst_again");
    cycle("rst_release_push", 1'b1, 8'h99, 1'b0, 1'b0);
    chk("rst_release_push:count1", 32'(Count), 32'd1);
    cycle("rst_release_low", 1'b0, 8'h00, 1'b0, 1'b0);
    drain("final_drain");

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uar_rx_fifo.md
# uar_rx_fifo

Receive-side byte buffer placed directly downstream of the UART RS232 receiver. Captures each completed character (`RxData` qualified by `RxDone`) into a circular FIFO. Presents the stored bytes on an AXI-Stream-style valid/ready master port to the AXI interface logic. Reports occupancy and a sticky overflow flag so software can detect dropped characters.

## Interface

**Parameters**
- `ADDR_W`, default 4: log2 of FIFO depth; depth = 2^ADDR_W (16 entries).
- `DATA_W`, default 8: character width; must match the receiver data width.

**Ports**
- `Clk`, in, 1: system clock; all logic on its rising edge.
- `Rst`, in, 1: reset, synchronous, active-high.
- `RxDone`, in, 1: receiver "character complete" strobe.
- `RxData`, in, DATA_W: received character; valid while `RxDone` is high.
- `m_tdata`, out, DATA_W: head-of-FIFO byte; 0 when empty.
- `m_tvalid`, out, 1: FIFO non-empty.
- `m_tready`, in, 1: consumer accepts the head byte.
- `Count`, out, ADDR_W+1: number of stored bytes, 0..2^ADDR_W.
- `Full`, out, 1: `Count == 2^ADDR_W`.
- `Empty`, out, 1: `Count == 0`.
- `Overflow`, out, 1: sticky; a character was dropped because the FIFO was full.
- `OvfClr`, in, 1: single-cycle clear of `Overflow`.

## Operation

- **Write detect**
  - `RxDone` is registered into `done_q`.
  - push = `RxDone & ~done_q`, so exactly one write per rising edge of `RxDone`, even if the strobe is stretched.
  - `RxData` is sampled in the push cycle.
- **Storage**
  - Register array of 2^ADDR_W x DATA_W.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_W bits and wrap modulo 2^ADDR_W with no special case.
  - A separate `Count` register is the single source of truth for full/empty; pointer comparison is not used.
- **Read (first-word fall-through)**
  - `m_tdata = mem[rd_ptr]` whenever `m_tvalid`; 8'h00 otherwise.
  - pop = `m_tvalid & m_tready`; on pop, `rd_ptr` increments.
  - `m_tdata` and `m_tvalid` must hold stable while `m_tvalid & ~m_tready`.
- **Accept rules**
  - push accepted when `~Full | pop`. A push into a full FIFO in the same cycle as a pop is accepted.
  - push while `Full & ~pop`: byte discarded; `wr_ptr` and `Count` unchanged; `Overflow` set.
  - pop while `Empty`: impossible, because `m_tvalid` = 0.
- **Count update**
  - +1 on accepted push without pop.
  - -1 on pop without accepted push.
  - Unchanged on both or neither.
- **Overflow**
  - Set on a dropped push; cleared by `OvfClr`.
  - Set wins over clear in the same cycle.
- **Reset values**
  - `wr_ptr`, `rd_ptr`, `Count`, `done_q`, `Overflow` = 0.
  - `m_tvalid` = 0, `m_tdata` = 0, `Empty` = 1, `Full` = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored bytes in one cycle; `Rst` dominates push, pop and `OvfClr`.

## Timing

- **Push latency:** `RxDone` rises in cycle T → byte written at end of T → `m_tvalid` = 1 and `m_tdata` = byte in T+1.
- **Pop:** handshake in cycle T → next entry (or empty) visible in T+1. Back-to-back pops sustain 1 byte/cycle.
- **`Count`, `Full`, `Empty`:** update in the cycle after the causing event, registered.
- **`Overflow`:** visible the cycle after the dropped push.
- **Stretched strobe:** `RxDone` held high N cycles → one write; a second write needs `RxDone` low for at least 1 cycle first.
- **Strobe at reset release:** `RxDone` high in the first cycle after `Rst` deasserts counts as a rising edge, because `done_q` resets to 0.

## Test plan

- **Basic push/pop:** reset, then push 0xA5 via a 1-cycle `RxDone` with `m_tready` = 0 → cycle+1: `m_tvalid` = 1, `m_tdata` = 0xA5, `Count` = 1. Assert `m_tready` for 1 cycle → `Empty` = 1, `m_tdata` = 0x00.
- **Fill to full with wrap:** push 0x00..0x0F → `Full` = 1, `Count` = 16. Pop 4 bytes (0x00..0x03 in order), push 0x10..0x13 → pops return 0x04..0x13 in order across the pointer wrap.
- **Overflow:** with `Full`, push 0xEE and `m_tready` = 0 → `Overflow` = 1, `Count` = 16, 0xEE never appears. Assert `OvfClr` together with another dropped push → `Overflow` stays 1. `OvfClr` alone → `Overflow` = 0.
- **Simultaneous push/pop:**
  - Full, push 0x55 in the same cycle as a pop → `Count` stays 16; 0x55 emerges last.
  - Count = 1 with simultaneous push/pop → `Count` stays 1, `m_tvalid` stays 1.
- **Stretched strobe and backpressure:** `RxDone` high for 5 cycles with `RxData` = 0x3C → `Count` = 1. With `m_tready` = 0 for 10 cycles, `m_tdata`/`m_tvalid` stay stable.
- **Reset mid-operation:** `Count` = 7, assert `Rst` in the same cycle as a push and a pop → next cycle `Count` = 0, `Empty` = 1, `m_tvalid` = 0, `Overflow` = 0.
